c2h_pkt_framer: RTL and testbench

C2H_PKT_FRAMER -- requirements
Module: c2h_pkt_framer

---
 rtl/c2h_pkg.sv | 12 +
 rtl/c2h_cmpt_fifo.sv | 46 ++++
 rtl/c2h_pkt_framer.sv | 165 ++++++++++++++++
 tb/tb_c2h_pkt_framer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c2h_pkg.sv
// Shared constants and the completion entry type for the C2H packet framer.
package c2h_pkg;

    localparam logic [111:0] EXP_HDR_DEFAULT = 112'h665544332211_665544332211_2121;
    localparam int MIN_PKT_BYTES = 64;

    typedef struct packed {
        logic [15:0] len;
        logic [15:0] pkt_id;
    } cmpt_entry_t;

endpackage

// File: rtl/c2h_cmpt_fifo.sv
// Register-based completion FIFO; head is visible whenever count is non-zero.
module c2h_cmpt_fifo
    import c2h_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  cmpt_entry_t   push_data,
    input  logic          pop,
    output cmpt_entry_t   head,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    cmpt_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic push_ok;
    logic pop_ok;

    // Requests against a full or empty FIFO are ignored rather than corrupting it.
    assign push_ok = push && (count != CW'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok) count <= count + CW'(1);
            else if (pop_ok && !push_ok) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/c2h_pkt_framer.sv
// Upstream-to-QDMA C2H framer: 2-entry skid buffer, per-packet length/ID
// completions, header check and sticky statistics.
module c2h_pkt_framer
    import c2h_pkg::*;
#(
    parameter int RX_LEN = 512,
    parameter int RX_BEN = RX_LEN / 8,
    parameter int CMPT_DEPTH = 4,
    parameter logic [111:0] EXP_HDR = EXP_HDR_DEFAULT
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [RX_LEN-1:0] rx_data,
    input  logic [RX_BEN-1:0] rx_ben,
    input  logic              rx_last,
    output logic              c2h_tvalid,
    input  logic              c2h_tready,
    output logic [RX_LEN-1:0] c2h_tdata,
    output logic [RX_BEN-1:0] c2h_tkeep,
    output logic              c2h_tlast,
    output logic              cmpt_valid,
    input  logic              cmpt_ready,
    output logic [15:0]       cmpt_len,
    output logic [15:0]       cmpt_pkt_id,
    input  logic              clr,
    output logic [31:0]       pkt_cnt,
    output logic              err_hdr,
    output logic              err_short,
    output logic              err_len
);
    localparam int CW = $clog2(CMPT_DEPTH) + 1;

    // Handshake: a transfer occurs on a rising edge where valid and ready are both high;
    // valid, once high, holds with its payload until that edge, and never depends on ready.
    logic              out_valid;
    logic              skid_valid;
    logic [RX_LEN-1:0] skid_data;
    logic [RX_BEN-1:0] skid_ben;
    logic              skid_last;
    logic              out_valid_n, skid_valid_n, load_out, out_from_skid, load_skid;
    logic              in_fire, out_fire, fifo_full, push;
    logic [CW-1:0]     cmpt_count;
    cmpt_entry_t       cmpt_head, push_entry;
    logic [15:0]       len_acc, pkt_id, len_sat;
    logic [16:0]       beat_bytes, len_sum;
    logic              sop;

    assign in_fire    = rx_valid && rx_ready;
    assign fifo_full  = (cmpt_count == CW'(CMPT_DEPTH));
    // A packet-ending beat waits until its completion has somewhere to go.
    assign c2h_tvalid = out_valid && !(c2h_tlast && fifo_full);
    assign out_fire   = c2h_tvalid && c2h_tready;

    always_comb begin
        out_valid_n   = out_valid;
        skid_valid_n  = skid_valid;
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        if (!out_valid || out_fire) begin
            if (skid_valid) begin
                load_out      = 1'b1;
                out_from_skid = 1'b1;
                out_valid_n   = 1'b1;
                skid_valid_n  = in_fire;
                load_skid     = in_fire;
            end else begin
                out_valid_n = in_fire;
                load_out    = in_fire;
            end
        end else if (in_fire) begin
            skid_valid_n = 1'b1;
            load_skid    = 1'b1;
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            rx_ready   <= 1'b0;
            c2h_tdata  <= '0;
            c2h_tkeep  <= '0;
            c2h_tlast  <= 1'b0;
            skid_data  <= '0;
            skid_ben   <= '0;
            skid_last  <= 1'b0;
        end else begin
            out_valid  <= out_valid_n;
            skid_valid <= skid_valid_n;
            rx_ready   <= !(out_valid_n && skid_valid_n);
            if (load_out) begin
                c2h_tdata <= out_from_skid ? skid_data : rx_data;
                c2h_tkeep <= out_from_skid ? skid_ben : rx_ben;
                c2h_tlast <= out_from_skid ? skid_last : rx_last;
            end
            if (load_skid) begin
                skid_data <= rx_data;
                skid_ben  <= rx_ben;
                skid_last <= rx_last;
            end
        end
    end

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < RX_BEN; i++) beat_bytes += 17'(c2h_tkeep[i]);
    end

    assign len_sum    = {1'b0, len_acc} + beat_bytes;
    assign len_sat    = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    assign push       = out_fire && c2h_tlast;
    assign push_entry = {len_sat, pkt_id};

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            len_acc   <= '0;
            pkt_id    <= '0;
            pkt_cnt   <= '0;
            sop       <= 1'b1;
            err_hdr   <= 1'b0;
            err_short <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            if (out_fire) begin
                sop <= c2h_tlast;
                if (c2h_tlast) begin
                    len_acc <= '0;
                    pkt_id  <= pkt_id + 16'd1;
                end else begin
                    len_acc <= len_sat;
                end
            end
            // Clear takes priority over any flag or count update in the same cycle.
            if (clr) begin
                pkt_cnt   <= '0;
                err_hdr   <= 1'b0;
                err_short <= 1'b0;
                err_len   <= 1'b0;
            end else begin
                if (push) pkt_cnt <= pkt_cnt + 32'd1;
                if (out_fire && sop && (c2h_tdata[111:0] != EXP_HDR)) err_hdr <= 1'b1;
                if (out_fire && len_sum[16]) err_len <= 1'b1;
                if (push && (len_sat < 16'(MIN_PKT_BYTES))) err_short <= 1'b1;
            end
        end
    end

    c2h_cmpt_fifo #(.DEPTH(CMPT_DEPTH), .CW(CW)) u_cmpt_fifo (
        .clk       (axi_aclk),
        .rst       (axi_areset),
        .push      (push),
        .push_data (push_entry),
        .pop       (cmpt_valid && cmpt_ready),
        .head      (cmpt_head),
        .count     (cmpt_count)
    );

    assign cmpt_valid  = (cmpt_count != '0);
    assign cmpt_len    = cmpt_head.len;
    assign cmpt_pkt_id = cmpt_head.pkt_id;

endmodule

// File: tb/tb_c2h_pkt_framer.sv
// Self-checking bench for c2h_pkt_framer: table of packets, hand sequences for
// stall/back-pressure/reset, and random traffic against a packet-level model.
module tb_c2h_pkt_framer;
    localparam int RX_LEN = 512;
    localparam int RX_BEN = 64;
    localparam int CMPT_DEPTH = 4;
    localparam logic [111:0] HDR = 112'h665544332211_665544332211_2121;

    logic              axi_aclk = 1'b0;
    logic              axi_areset;
    logic              rx_valid, rx_ready, rx_last;
    logic [RX_LEN-1:0] rx_data;
    logic [RX_BEN-1:0] rx_ben;
    logic              c2h_tvalid, c2h_tready, c2h_tlast;
    logic [RX_LEN-1:0] c2h_tdata;
    logic [RX_BEN-1:0] c2h_tkeep;
    logic              cmpt_valid, cmpt_ready;
    logic [15:0]       cmpt_len, cmpt_pkt_id;
    logic              clr;
    logic [31:0]       pkt_cnt;
    logic              err_hdr, err_short, err_len;

    c2h_pkt_framer #(.RX_LEN(RX_LEN), .RX_BEN(RX_BEN), .CMPT_DEPTH(CMPT_DEPTH)) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_ben(rx_ben), .rx_last(rx_last),
        .c2h_tvalid(c2h_tvalid), .c2h_tready(c2h_tready), .c2h_tdata(c2h_tdata),
        .c2h_tkeep(c2h_tkeep), .c2h_tlast(c2h_tlast),
        .cmpt_valid(cmpt_valid), .cmpt_ready(cmpt_ready), .cmpt_len(cmpt_len), .cmpt_pkt_id(cmpt_pkt_id),
        .clr(clr), .pkt_cnt(pkt_cnt), .err_hdr(err_hdr), .err_short(err_short), .err_len(err_len)
    );

    initial forever #5 axi_aclk = ~axi_aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tready_mode, cmpt_mode;
    bit gap_mode, lat_rec;

    // Reference model state: expected output beats and completions in order.
    logic [RX_LEN-1:0] exp_data_q[$];
    logic [RX_BEN-1:0] exp_ben_q[$];
    logic              exp_last_q[$];
    logic [31:0]       exp_cmpt_q[$];
    int                acc_cyc_q[$];
    int                out_cyc_q[$];
    logic [15:0]       exp_pkt_id;
    logic [31:0]       m_pkt_cnt;
    bit                m_err_hdr, m_err_short, m_err_len;
    logic [15:0]       last_cmpt_len, last_cmpt_id;

    typedef struct {
        int          nbytes;
        bit          bad_hdr;
        logic [15:0] exp_len;
        bit          exp_hdr;
        bit          exp_short;
        bit          exp_elen;
    } vec_t;
    vec_t vec[8];

    initial forever @(posedge axi_aclk) cyc++;

    initial forever begin
        @(posedge axi_aclk);
        #1;
        case (tready_mode)
            0: c2h_tready = 1'b1;
            1: c2h_tready = ~c2h_tready;
            2: c2h_tready = 1'($urandom_range(0, 1));
            default: ;
        endcase
        case (cmpt_mode)
            0: cmpt_ready = 1'b1;
            2: cmpt_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RX_LEN-1:0] rand_beat();
        logic [RX_LEN-1:0] r;
        for (int i = 0; i < RX_LEN / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive_beat(input logic [RX_LEN-1:0] d, input logic [RX_BEN-1:0] b, input logic l);
        int budget;
        bit taken;
        rx_data = d; rx_ben = b; rx_last = l; rx_valid = 1'b1;
        taken = 1'b0;
        budget = 0;
        while (!taken && budget < 3000) begin
            @(negedge axi_aclk);
            taken = rx_ready;
            if (taken && lat_rec) acc_cyc_q.push_back(cyc);
            @(posedge axi_aclk);
            #1;
            budget++;
        end
        rx_valid = 1'b0;
        checks++;
        if (!taken) begin
            errors++;
            $display("FAIL rx_accept: beat not accepted within %0d cycles", budget);
        end
    endtask

    task automatic send_pkt(input int nbytes, input bit bad_hdr);
        int beats, rem, len;
        logic [RX_LEN-1:0] d;
        logic [RX_BEN-1:0] b;
        beats = (nbytes + RX_BEN - 1) / RX_BEN;
        len = (nbytes > 65535) ? 65535 : nbytes;
        exp_cmpt_q.push_back({16'(len), exp_pkt_id});
        exp_pkt_id++;
        m_pkt_cnt++;
        if (len < 64) m_err_short = 1'b1;
        if (bad_hdr) m_err_hdr = 1'b1;
        if (nbytes > 65535) m_err_len = 1'b1;
        for (int i = 0; i < beats; i++) begin
            d = rand_beat();
            if (i == 0) begin
                d[111:0] = HDR;
                if (bad_hdr) d[7:0] = 8'h00;
            end
            rem = nbytes - i * RX_BEN;
            b = (rem >= RX_BEN) ? {RX_BEN{1'b1}} : ({RX_BEN{1'b1}} >> (RX_BEN - rem));
            exp_data_q.push_back(d);
            exp_ben_q.push_back(b);
            exp_last_q.push_back(i == beats - 1);
            if (gap_mode && $urandom_range(0, 3) == 0) begin
                @(posedge axi_aclk);
                #1;
            end
            drive_beat(d, b, i == beats - 1);
        end
    endtask

    task automatic drain();
        int budget = 0;
        while ((exp_data_q.size() != 0 || exp_cmpt_q.size() != 0) && budget < 5000) begin
            @(posedge axi_aclk);
            budget++;
        end
        checks++;
        if (budget >= 5000) begin
            errors++;
            $display("FAIL drain: %0d beats and %0d completions still outstanding", exp_data_q.size(), exp_cmpt_q.size());
        end
        repeat (2) @(posedge axi_aclk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge axi_aclk);
        #1;
        clr = 1'b0;
        m_pkt_cnt = '0; m_err_hdr = 1'b0; m_err_short = 1'b0; m_err_len = 1'b0;
        @(negedge axi_aclk);
        check("clr_pkt_cnt", pkt_cnt, 0);
        check("clr_err_hdr", err_hdr, 0);
        check("clr_err_short", err_short, 0);
        check("clr_err_len", err_len, 0);
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic check_stats(input string tag);
        @(negedge axi_aclk);
        check({tag, "_pkt_cnt"}, pkt_cnt, m_pkt_cnt);
        check({tag, "_err_hdr"}, err_hdr, m_err_hdr);
        check({tag, "_err_short"}, err_short, m_err_short);
        check({tag, "_err_len"}, err_len, m_err_len);
        @(posedge axi_aclk);
        #1;
    endtask

    // Output monitor: beat order/content, stall stability, completion order, full-FIFO hold.
    initial begin
        logic prev_stall;
        logic [RX_LEN-1:0] pd, ed;
        logic [RX_BEN-1:0] pb, eb;
        logic pl, el;
        logic [31:0] ec;
        int outstanding;
        prev_stall = 1'b0;
        outstanding = 0;
        forever begin
            @(negedge axi_aclk);
            if (axi_areset) begin
                prev_stall = 1'b0;
                outstanding = 0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!c2h_tvalid || c2h_tdata !== pd || c2h_tkeep !== pb || c2h_tlast !== pl) begin
                        errors++;
                        $display("FAIL c2h_hold: got valid=%0b last=%0b keep=%h, required valid=1 last=%0b keep=%h",
                                 c2h_tvalid, c2h_tlast, c2h_tkeep, pl, pb);
                    end
                end
                if (outstanding == CMPT_DEPTH && c2h_tvalid) check("full_tlast_hold", c2h_tlast, 0);
                if (c2h_tvalid && c2h_tready) begin
                    checks++;
                    if (exp_data_q.size() == 0) begin
                        errors++;
                        $display("FAIL c2h_extra: got unexpected beat keep=%h, required none", c2h_tkeep);
                    end else begin
                        ed = exp_data_q.pop_front();
                        eb = exp_ben_q.pop_front();
                        el = exp_last_q.pop_front();
                        if (c2h_tdata !== ed || c2h_tkeep !== eb || c2h_tlast !== el) begin
                            errors++;
                            $display("FAIL c2h_beat: got last=%0b keep=%h data=%h, required last=%0b keep=%h data=%h",
                                     c2h_tlast, c2h_tkeep, c2h_tdata[63:0], el, eb, ed[63:0]);
                        end
                    end
                    if (lat_rec) out_cyc_q.push_back(cyc);
                    if (c2h_tlast) outstanding++;
                end
                if (cmpt_valid && cmpt_ready) begin
                    checks++;
                    if (exp_cmpt_q.size() == 0) begin
                        errors++;
                        $display("FAIL cmpt_extra: got len=%0d id=%0d, required none", cmpt_len, cmpt_pkt_id);
                    end else begin
                        ec = exp_cmpt_q.pop_front();
                        if ({cmpt_len, cmpt_pkt_id} !== ec) begin
                            errors++;
                            $display("FAIL cmpt: got len=%0d id=%0d, required len=%0d id=%0d",
                                     cmpt_len, cmpt_pkt_id, ec[31:16], ec[15:0]);
                        end
                    end
                    last_cmpt_len = cmpt_len;
                    last_cmpt_id = cmpt_pkt_id;
                    outstanding--;
                end
                prev_stall = c2h_tvalid && !c2h_tready;
                pd = c2h_tdata; pb = c2h_tkeep; pl = c2h_tlast;
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RX_LEN-1:0] d;
        vec[0] = '{128,   1'b0, 16'd128,   1'b0, 1'b0, 1'b0};
        vec[1] = '{100,   1'b0, 16'd100,   1'b0, 1'b0, 1'b0};
        vec[2] = '{40,    1'b1, 16'd40,    1'b1, 1'b1, 1'b0};
        vec[3] = '{64,    1'b0, 16'd64,    1'b0, 1'b0, 1'b0};
        vec[4] = '{63,    1'b0, 16'd63,    1'b0, 1'b1, 1'b0};
        vec[5] = '{1,     1'b0, 16'd1,     1'b0, 1'b1, 1'b0};
        vec[6] = '{65535, 1'b0, 16'hFFFF,  1'b0, 1'b0, 1'b0};
        vec[7] = '{70400, 1'b0, 16'hFFFF,  1'b0, 1'b0, 1'b1};

        rx_valid = 1'b0; rx_data = '0; rx_ben = '0; rx_last = 1'b0;
        c2h_tready = 1'b0; cmpt_ready = 1'b0; clr = 1'b0;
        tready_mode = 3; cmpt_mode = 3; gap_mode = 1'b0; lat_rec = 1'b0;
        exp_pkt_id = '0; m_pkt_cnt = '0; m_err_hdr = 1'b0; m_err_short = 1'b0; m_err_len = 1'b0;
        axi_areset = 1'b1;

        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_c2h_tvalid", c2h_tvalid, 0);
        check("rst_c2h_tlast", c2h_tlast, 0);
        check("rst_cmpt_valid", cmpt_valid, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_errs", {err_hdr, err_short, err_len}, 0);
        @(posedge axi_aclk);
        #1;
        axi_areset = 1'b0;
        @(posedge axi_aclk);
        @(negedge axi_aclk);
        check("rx_ready_after_rst", rx_ready, 1);
        @(posedge axi_aclk);
        #1;
        tready_mode = 0; cmpt_mode = 0;

        for (int i = 0; i < 8; i++) begin
            pulse_clr();
            lat_rec = (i == 0);
            send_pkt(vec[i].nbytes, vec[i].bad_hdr);
            drain();
            lat_rec = 1'b0;
            @(negedge axi_aclk);
            check($sformatf("vec%0d_len", i), last_cmpt_len, vec[i].exp_len);
            check($sformatf("vec%0d_err_hdr", i), err_hdr, vec[i].exp_hdr);
            check($sformatf("vec%0d_err_short", i), err_short, vec[i].exp_short);
            check($sformatf("vec%0d_err_len", i), err_len, vec[i].exp_elen);
            check($sformatf("vec%0d_pkt_cnt", i), pkt_cnt, 1);
            @(posedge axi_aclk);
            #1;
        end

        check("latency_beats", out_cyc_q.size(), 2);
        for (int k = 0; k < 2 && k < out_cyc_q.size() && k < acc_cyc_q.size(); k++)
            check($sformatf("latency_beat%0d", k), 64'(out_cyc_q[k] - acc_cyc_q[k]), 1);

        // Output ready toggling every cycle.
        tready_mode = 1;
        for (int i = 0; i < 10; i++) send_pkt($urandom_range(1, 200), 1'b0);
        drain();
        check_stats("toggle");

        // Completion back-pressure: four queued, fifth tlast held, skid fills behind it.
        pulse_clr();
        tready_mode = 0; cmpt_mode = 3; cmpt_ready = 1'b0;
        repeat (6) send_pkt(64, 1'b0);
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        check("bp_c2h_tvalid", c2h_tvalid, 0);
        check("bp_rx_ready", rx_ready, 0);
        check("bp_cmpt_valid", cmpt_valid, 1);
        check("bp_pkt_cnt", pkt_cnt, 4);
        @(posedge axi_aclk);
        #1;
        cmpt_mode = 0;
        drain();
        check_stats("bp_release");

        // Random traffic with random back-pressure on both outputs.
        tready_mode = 2; cmpt_mode = 2; gap_mode = 1'b1;
        for (int i = 0; i < 40; i++) send_pkt($urandom_range(1, 260), $urandom_range(0, 7) == 0);
        drain();
        check_stats("random");
        gap_mode = 1'b0; tready_mode = 0; cmpt_mode = 0;

        // Reset in the middle of a packet.
        d = rand_beat();
        d[111:0] = HDR;
        exp_data_q.push_back(d); exp_ben_q.push_back({RX_BEN{1'b1}}); exp_last_q.push_back(1'b0);
        drive_beat(d, {RX_BEN{1'b1}}, 1'b0);
        repeat (2) @(posedge axi_aclk);
        @(negedge axi_aclk);
        #2;
        axi_areset = 1'b1;
        #1;
        check("midrst_rx_ready", rx_ready, 0);
        check("midrst_c2h_tvalid", c2h_tvalid, 0);
        check("midrst_c2h_tlast", c2h_tlast, 0);
        check("midrst_cmpt_valid", cmpt_valid, 0);
        check("midrst_pkt_cnt", pkt_cnt, 0);
        check("midrst_errs", {err_hdr, err_short, err_len}, 0);
        exp_data_q.delete(); exp_ben_q.delete(); exp_last_q.delete(); exp_cmpt_q.delete();
        exp_pkt_id = '0; m_pkt_cnt = '0; m_err_hdr = 1'b0; m_err_short = 1'b0; m_err_len = 1'b0;
        repeat (2) @(posedge axi_aclk);
        #1;
        axi_areset = 1'b0;
        repeat (2) @(posedge axi_aclk);
        #1;
        send_pkt(128, 1'b0);
        drain();
        check("postrst_pkt_id", last_cmpt_id, 0);
        check("postrst_len", last_cmpt_len, 128);
        check_stats("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
